iter_div_param: RTL and testbench

- Parametrised, multi-cycle radix-2 restoring integer divider. It is the next-generation replacement for the fixed 32-bit iterative divider in the ALU execute stage.
- Adds generic WIDTH, a pass-through request tag, output backpressure, flush/abort, and explicit divide-by-zero handling with a fast path.
- One operation in flight. It sits between the issue stage (in_* side) and the writeback arbiter (out_* side).

---
 rtl/iter_div_param.sv | 91 +++++++++
 tb/tb_iter_div_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_param.sv
// iter_div_param: multi-cycle radix-2 restoring divider with tag, backpressure, flush and divide-by-zero fast path
module iter_div_param #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, rem, ym, xm_in, ym_in, sub;
  logic [WIDTH:0] part;
  logic [TAG_W-1:0] tag_r;
  logic neg_q, neg_r, accept, borrow;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready & ~flush;
  assign xm_in     = (div_signed & x[WIDTH-1]) ? -x : x;
  assign ym_in     = (div_signed & y[WIDTH-1]) ? -y : y;
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  assign part      = {rem, dvd[WIDTH-1]};
  assign borrow    = part < {1'b0, ym};
  assign sub       = part[WIDTH-1:0] - ym;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = accept ? ((y == '0) ? DONE : CALC) : IDLE;
      CALC: nxt = (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
      FIX:  nxt = DONE;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dvd <= '0;
      rem <= '0;
      ym <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      tag_r <= '0;
      q <= '0;
      r <= '0;
      dz <= 1'b0;
      out_tag <= '0;
    end else if (accept) begin
      cnt <= '0;
      dvd <= xm_in;
      rem <= '0;
      ym <= ym_in;
      neg_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
      neg_r <= div_signed & x[WIDTH-1];
      tag_r <= in_tag;
      if (y == '0) begin
        q <= '1;
        r <= x;
        dz <= 1'b1;
        out_tag <= in_tag;
      end
    end else if (state == CALC && !flush) begin
      dvd <= {dvd[WIDTH-2:0], ~borrow};
      rem <= borrow ? part[WIDTH-1:0] : sub;
      cnt <= cnt + 1'b1;
    end else if (state == FIX && !flush) begin
      q <= neg_q ? -dvd : dvd;
      r <= neg_r ? -rem : rem;
      dz <= 1'b0;
      out_tag <= tag_r;
    end
  end
endmodule

// File: tb/tb_iter_div_param.sv
// tb_iter_div_param: directed 32-bit checks plus a randomized 8-bit sweep against an arithmetic reference
module tb_iter_div_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic fl, iv, ir, ds, ov, ordy, dzo;
  logic [31:0] xa, ya, qo, ro;
  logic [3:0] itag, otag;
  logic fl8, iv8, ir8, ds8, ov8, ordy8, dz8;
  logic [7:0] x8, y8, q8, r8;
  logic [3:0] itag8, otag8;
  int vectors = 0, errs = 0;

  iter_div_param #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset(reset), .flush(fl), .in_valid(iv), .in_ready(ir), .div_signed(ds),
    .x(xa), .y(ya), .in_tag(itag), .out_valid(ov), .out_ready(ordy), .q(qo), .r(ro),
    .dz(dzo), .out_tag(otag));

  iter_div_param #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .reset(reset), .flush(fl8), .in_valid(iv8), .in_ready(ir8), .div_signed(ds8),
    .x(x8), .y(y8), .in_tag(itag8), .out_valid(ov8), .out_ready(ordy8), .q(q8), .r(r8),
    .dz(dz8), .out_tag(otag8));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref8(input logic s, input logic [7:0] a, input logic [7:0] b,
                               output logic [7:0] eq, output logic [7:0] er, output logic edz);
    int ia, ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    if (b == 8'd0) begin
      eq = 8'hff;
      er = a;
      edz = 1'b1;
    end else begin
      eq = 8'(ia / ib);
      er = 8'(ia % ib);
      edz = 1'b0;
    end
  endfunction

  task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                      input logic [31:0] eq, input logic [31:0] er, input logic edz,
                      input int elat, input int hold);
    int lat;
    logic busy_ok, stable_ok;
    chk("idle_ready", 80'(ir), 80'(1));
    ds = s; xa = a; ya = b; itag = tg; iv = 1'b1;
    step;
    iv = 1'b0; xa = $urandom; ya = $urandom; ds = 1'($urandom); itag = 4'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!ov && lat < 100) begin
      busy_ok &= !ir;
      step;
      lat++;
    end
    busy_ok &= !ir;
    chk("latency", 80'(lat), 80'(elat));
    chk("busy", 80'(busy_ok), 80'(1));
    chk("result", 80'({qo, ro, dzo, otag}), 80'({eq, er, edz, tg}));
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step;
      stable_ok &= ov && !ir && ({qo, ro, dzo, otag} === {eq, er, edz, tg});
    end
    if (hold > 0) chk("hold_stable", 80'(stable_ok), 80'(1));
    ordy = 1'b1;
    step;
    ordy = 1'b0;
    chk("retire", 80'({ov, ir}), 80'(2'b01));
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b);
    ds = 1'b0; xa = a; ya = b; itag = 4'h5; iv = 1'b1;
    step;
    iv = 1'b0;
  endtask

  initial begin
    logic seen, flushed, ok, hs, edz, s;
    logic [7:0] eq, er, xv, yv;
    logic [3:0] tg;
    int lat, fl_at, n;
    reset = 1'b1;
    {fl, iv, ds, ordy, fl8, iv8, ds8, ordy8} = '0;
    {xa, ya, itag, x8, y8, itag8} = '0;
    repeat (2) step;
    reset = 1'b0;
    chk("reset32", 80'({ov, ir, qo, ro, dzo, otag}), 80'({2'b01, 64'd0, 1'b0, 4'd0}));
    chk("reset8", 80'({ov8, ir8, q8, r8, dz8, otag8}), 80'({2'b01, 16'd0, 1'b0, 4'd0}));

    op32(1'b0, 32'd100, 32'd7, 4'h1, 32'd14, 32'd2, 1'b0, 34, 0);
    op32(1'b1, -32'sd7, 32'd2, 4'h2, 32'hfffffffd, 32'hffffffff, 1'b0, 34, 0);
    op32(1'b1, 32'd7, -32'sd2, 4'h4, 32'hfffffffd, 32'd1, 1'b0, 34, 0);
    op32(1'b1, 32'h80000000, 32'hffffffff, 4'h6, 32'h80000000, 32'd0, 1'b0, 34, 0);
    op32(1'b1, 32'h12345678, 32'd0, 4'h7, 32'hffffffff, 32'h12345678, 1'b1, 1, 0);
    op32(1'b0, 32'h12345678, 32'd0, 4'h8, 32'hffffffff, 32'h12345678, 1'b1, 1, 0);
    op32(1'b0, 32'd50, 32'd5, 4'h9, 32'd10, 32'd0, 1'b0, 34, 0);
    op32(1'b0, 32'd1000, 32'd33, 4'h3, 32'd30, 32'd10, 1'b0, 34, 10);
    op32(1'b1, -32'sd1000, 32'd33, 4'hA, 32'hffffffe2, 32'hfffffff6, 1'b0, 34, 3);

    issue32(32'd1000, 32'd3);
    repeat (5) step;
    fl = 1'b1;
    step;
    fl = 1'b0;
    chk("flush_calc", 80'({ov, ir}), 80'(2'b01));
    seen = 1'b0;
    repeat (40) begin step; seen |= ov; end
    chk("flush_calc_quiet", 80'(seen), 80'(0));
    op32(1'b0, 32'd9, 32'd3, 4'hB, 32'd3, 32'd0, 1'b0, 34, 0);

    issue32(32'd1000, 32'd3);
    repeat (40) step;
    chk("done_before_flush", 80'(ov), 80'(1));
    fl = 1'b1;
    step;
    fl = 1'b0;
    chk("flush_done", 80'({ov, ir}), 80'(2'b01));
    op32(1'b0, 32'd9, 32'd3, 4'hC, 32'd3, 32'd0, 1'b0, 34, 0);

    xa = 32'd9; ya = 32'd3; iv = 1'b1; fl = 1'b1;
    step;
    iv = 1'b0; fl = 1'b0;
    chk("flush_idle", 80'({ov, ir}), 80'(2'b01));
    seen = 1'b0;
    repeat (40) begin step; seen |= ov; end
    chk("flush_idle_quiet", 80'(seen), 80'(0));

    issue32(32'd1000, 32'd3);
    repeat (5) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("reset_calc", 80'({ov, ir, qo, ro, dzo, otag}), 80'({2'b01, 64'd0, 1'b0, 4'd0}));
    op32(1'b0, 32'd9, 32'd3, 4'hD, 32'd3, 32'd0, 1'b0, 34, 0);
    issue32(32'd1000, 32'd7);
    repeat (40) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("reset_done", 80'({ov, ir, qo, ro, dzo, otag}), 80'({2'b01, 64'd0, 1'b0, 4'd0}));
    op32(1'b0, 32'd9, 32'd3, 4'hE, 32'd3, 32'd0, 1'b0, 34, 0);

    for (int k = 0; k < 3000; k++) begin
      s = 1'($urandom);
      xv = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
      n = $urandom_range(0, 9);
      yv = (n == 0) ? 8'h00 : (n == 1) ? 8'hff : 8'($urandom);
      tg = 4'($urandom);
      ref8(s, xv, yv, eq, er, edz);
      chk("rnd_ready", 80'(ir8), 80'(1));
      ds8 = s; x8 = xv; y8 = yv; itag8 = tg; iv8 = 1'b1;
      step;
      iv8 = 1'b0;
      lat = 1;
      fl_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 9) : 0;
      flushed = 1'b0;
      while (!ov8 && lat < 40) begin
        ds8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom); itag8 = 4'($urandom);
        ordy8 = 1'($urandom);
        if (lat == fl_at) begin
          fl8 = 1'b1;
          step;
          fl8 = 1'b0;
          flushed = 1'b1;
          break;
        end
        step;
        lat++;
      end
      if (flushed) begin
        chk("rnd_flush", 80'({ov8, ir8}), 80'(2'b01));
        continue;
      end
      chk("rnd_latency", 80'(lat), 80'(edz ? 1 : 10));
      chk("rnd_result", 80'({q8, r8, dz8, otag8}), 80'({eq, er, edz, tg}));
      ok = 1'b1;
      hs = 1'b0;
      n = 0;
      while (!hs && n < 50) begin
        ordy8 = 1'($urandom);
        hs = ordy8;
        step;
        n++;
        if (!hs) ok &= ov8 && !ir8 && ({q8, r8, dz8, otag8} === {eq, er, edz, tg});
      end
      ordy8 = 1'b0;
      chk("rnd_retire", 80'({ok, hs, ov8, ir8}), 80'(4'b1101));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
